// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory arbiter
// Provides the access-size and FSM-state enums, the latched request record and the
// alignment check used to suppress misaligned stores and flag errors.
package dmem_pkg;

    // Request record fields are sized for the widest supported port (32 bits).
    localparam int REQ_AW = 32;
    localparam int REQ_DW = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_type_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_e;

    typedef struct packed {
        logic              we;
        mem_type_e         mtype;
        logic              sign;
        logic [REQ_AW-1:0] addr;
        logic [REQ_DW-1:0] wdata;
    } mem_req_t;

    function automatic logic misaligned(input mem_type_e t, input logic [1:0] a);
        return (t == MEM_HALF && a[0]) || (t == MEM_WORD && a != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way grant selection from request valids
// Ports: valid[1:0] requests, last_grant (1 = m1 won last), grant[1:0] one-hot or zero.
// When both request, the side that did not win last time is chosen, or m0 under FIXED_PRIO.
module dmem_rr_pick #(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb grant = (&valid) ? ((FIXED_PRIO != 0 || last_grant) ? 2'b01 : 2'b10) : valid;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between m0 (core LSU) and m1 (debug/DMA)
// Ports: clk_i/rst_ni (async active-low); per requester mN_* request channel
// (valid/ready/write_en/mem_type/mem_sign/addr/write_data) and response channel
// (rvalid/rready/read_data/err); mem_* drive the memory for exactly one ISSUE cycle,
// mem_read_data_i is the memory's combinational read data.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  m0_valid_i,
    output logic                  m0_ready_o,
    input  logic                  m0_write_en_i,
    input  mem_type_e             m0_mem_type_i,
    input  logic                  m0_mem_sign_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_write_data_i,
    output logic                  m0_rvalid_o,
    input  logic                  m0_rready_i,
    output logic [DATA_WIDTH-1:0] m0_read_data_o,
    output logic                  m0_err_o,
    input  logic                  m1_valid_i,
    output logic                  m1_ready_o,
    input  logic                  m1_write_en_i,
    input  mem_type_e             m1_mem_type_i,
    input  logic                  m1_mem_sign_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_write_data_i,
    output logic                  m1_rvalid_o,
    input  logic                  m1_rready_i,
    output logic [DATA_WIDTH-1:0] m1_read_data_o,
    output logic                  m1_err_o,
    output logic                  mem_write_en_o,
    output mem_type_e             mem_type_o,
    output logic                  mem_sign_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    input  logic [DATA_WIDTH-1:0] mem_read_data_i
);

    arb_state_e            state;
    mem_req_t              req, req0, req1;
    logic                  owner, last_grant, rvalid, err, idle, issue, mis, rready;
    logic [1:0]            grant;
    logic [DATA_WIDTH-1:0] rdata;

    dmem_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .valid     ({m1_valid_i, m0_valid_i}),
        .last_grant(last_grant),
        .grant     (grant)
    );

    assign req0 = '{m0_write_en_i, m0_mem_type_i, m0_mem_sign_i, REQ_AW'(m0_addr_i), REQ_DW'(m0_write_data_i)};
    assign req1 = '{m1_write_en_i, m1_mem_type_i, m1_mem_sign_i, REQ_AW'(m1_addr_i), REQ_DW'(m1_write_data_i)};

    // Ready is masked by reset so every output reads 0 while rst_ni is low.
    assign idle       = rst_ni && state == IDLE;
    assign m0_ready_o = idle & grant[0];
    assign m1_ready_o = idle & grant[1];

    // Memory port is decoded from the state register, so an async reset drops the
    // write enable immediately.
    assign issue            = state == ISSUE;
    assign mis              = misaligned(req.mtype, req.addr[1:0]);
    assign mem_write_en_o   = issue & req.we & ~mis;
    assign mem_type_o       = issue ? req.mtype : MEM_BYTE;
    assign mem_sign_o       = issue & req.sign;
    assign mem_addr_o       = issue ? ADDR_WIDTH'(req.addr) : '0;
    assign mem_write_data_o = issue ? DATA_WIDTH'(req.wdata) : '0;

    assign m0_rvalid_o    = rvalid & ~owner;
    assign m1_rvalid_o    = rvalid & owner;
    assign m0_read_data_o = m0_rvalid_o ? rdata : '0;
    assign m1_read_data_o = m1_rvalid_o ? rdata : '0;
    assign m0_err_o       = m0_rvalid_o & err;
    assign m1_err_o       = m1_rvalid_o & err;
    assign rready         = owner ? m1_rready_i : m0_rready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            req        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rvalid     <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|grant) begin
                    req        <= grant[1] ? req1 : req0;
                    owner      <= grant[1];
                    last_grant <= grant[1];
                    state      <= ISSUE;
                end
                ISSUE: begin
                    rdata  <= (req.we | mis) ? '0 : mem_read_data_i;
                    err    <= mis;
                    rvalid <= 1'b1;
                    state  <= RESP;
                end
                RESP: if (rready) begin
                    rvalid <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
